// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Each operation runs IDLE -> EXEC -> RESP, and only one operation is in flight at a time.
module alu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 3,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_y,
    output logic              rsp0_zero,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_y,
    output logic              rsp1_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_next;
    logic              prio;
    logic              owner;
    logic [DATA_W-1:0] op_a, op_b, res_y;
    logic [CTRL_W-1:0] op_ctrl;
    logic              res_zero;
    logic              grant_sel;
    logic              accept;
    logic              rsp_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A lone requester wins outright; prio only breaks ties.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        grant_sel  = (req0_valid && req1_valid) ? prio : req1_valid;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_sel;
                    req1_ready = grant_sel;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                rsp_done   = owner ? rsp1_ready : rsp0_ready;
                if (rsp_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand and result registers keep their values between operations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio     <= RR_INIT;
            owner    <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_ctrl  <= '0;
            res_y    <= '0;
            res_zero <= 1'b0;
        end else begin
            if (accept) begin
                owner   <= grant_sel;
                op_a    <= grant_sel ? req1_a    : req0_a;
                op_b    <= grant_sel ? req1_b    : req0_b;
                op_ctrl <= grant_sel ? req1_ctrl : req0_ctrl;
            end
            if (state == EXEC) begin
                res_y    <= alu_y;
                res_zero <= alu_zero;
            end
            if (rsp_done) begin
                prio <= ~owner;
            end
        end
    end

    assign alu_a     = op_a;
    assign alu_b     = op_b;
    assign alu_ctrl  = op_ctrl;
    assign rsp0_y    = res_y;
    assign rsp1_y    = res_y;
    assign rsp0_zero = res_zero;
    assign rsp1_zero = res_zero;
    assign busy      = (state != IDLE);

endmodule
